sram_bus_slave: RTL
===================

# sram_bus_slave

Responder end of `Bus_if`: accepts the data-bus read/write requests issued by the memory stage and executes them against an external asynchronous 32-bit SRAM. It converts the single-cycle bus request into a multi-cycle SRAM access sequence. It holds `stall` high until the access completes. It returns read data on the word the master sees with `stall` low. It sits between the CPU data-bus master and the board SRAM pins.

## Interface
- `WAIT_CYCLES`, 2, SRAM access/pulse length in clocks; legal range ≥1.
- `ADDR_WIDTH`, 20, SRAM word-address width.
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `bus`  `Bus_if.slave`  –  inputs `address[31:0]`, `read`, `write`, `data_wr[31:0]`, `mask[3:0]`; outputs `data_rd[31:0]`, `stall`.
- `sram_addr`  out  ADDR_WIDTH  word address, `bus.address[ADDR_WIDTH+1:2]`.
- `sram_data_i`  in  32  data from SRAM pins.
- `sram_data_o`  out  32  data to SRAM pins.
- `sram_data_oe`  out  1  1 = drive `sram_data_o` onto pins.
- `sram_ce_n`  out  1  chip enable, active-low.
- `sram_oe_n`  out  1  output enable, active-low.
- `sram_we_n`  out  1  write enable, active-low.
- `sram_be_n`  out  4  byte enables, active-low.

## Operation
- States: IDLE, READ, WSETUP, WPULSE, WHOLD, DONE; one wait counter.
- **IDLE**:
  - `stall` = `read | write`, combinational, same cycle the request appears.
  - On a request, latch address, `data_wr` and `mask`.
  - `write` → WSETUP. Otherwise `read` → READ. `write` wins if both are asserted.
- **READ**:
  - Drives `ce_n=0`, `oe_n=0`, `we_n=1`, `be_n=0000` (full word; the master extracts bytes), `data_oe=0`.
  - Stays WAIT_CYCLES cycles.
  - On the last cycle, capture `sram_data_i` into the `data_rd` register; go to DONE.
- **WSETUP** (1 cycle): `ce_n=0`, `we_n=1`, `oe_n=1`, `be_n=~mask`, `data_oe=1`, `data_o`=latched `data_wr`.
- **WPULSE** (WAIT_CYCLES cycles): as WSETUP but `we_n=0`.
- **WHOLD** (1 cycle): as WSETUP (`we_n=1`, data still driven); go to DONE.
- **DONE** (1 cycle):
  - `stall=0`; SRAM controls idle. Next state IDLE.
  - Any request present in this cycle is the completing one and is not re-started.
- `data_rd` is a register. It holds the last captured read word in all states and is not updated by writes.
- Once started, an access always completes. Bus inputs are ignored outside IDLE, so a flushed or changed request does not abort an in-flight SRAM write.
- `stall` = 1 in READ, WSETUP, WPULSE and WHOLD.
- Idle pin values: `ce_n=oe_n=we_n=1`, `be_n=1111`, `data_oe=0`.
- `sram_addr` and `sram_data_o` come from the latched request registers.

## Timing
- Reset:
  - All outputs registered from state; next edge gives state IDLE and counter 0.
  - `data_rd=0`, SRAM controls at idle values, `stall=0` unless a request is present in IDLE.
- Reset during any access returns to IDLE at that edge. The write pulse is truncated (`we_n=1`) and no DONE cycle is issued.
- Read, request at cycle 0: READ in cycles 1..W, DONE at cycle W+1. `stall` is high for W+1 cycles. Data is valid at cycle W+1.
- Write, request at cycle 0: WSETUP at 1, WPULSE at 2..W+1, WHOLD at W+2, DONE at W+3. `stall` is high for W+3 cycles.
- Back-to-back requests: a new request is accepted in the IDLE cycle following DONE. There is one DONE cycle and no bubble beyond it.
- Counter width is `$clog2(WAIT_CYCLES+1)`. It resets to 0 on each state entry and never wraps.

## Structure
- `SramState_t` enum and idle-level constants (`SRAM_BE_IDLE = 4'b1111`) go in the shared `cpu_defs.svh` package, alongside `Word_t`.
- A single flat module. The counter and FSM are small, so a sub-module is not natural. Tristate pads are instantiated at the top level from `sram_data_o` / `sram_data_oe`.

## Test plan
- **Reset values**: assert `rst` with `read=1` → after the edge, state IDLE, `data_rd=0`, `ce_n=1`, `be_n=1111`, `data_oe=0`.
- **Read, W=2**: `read`, address `0x0000_0010`, SRAM model returns `0xDEADBEEF` → `sram_addr=4`; `stall` high for cycles 0–2; cycle 3 gives `stall=0`, `data_rd=0xDEADBEEF`.
- **Byte write**: `write`, `mask=0100`, `data_wr=0x00AB_0000`, address `0x8` → `be_n=1011`; `we_n` low exactly cycles 2–3; `data_oe` high cycles 1–4; DONE at cycle 5; model word byte 2 = `0xAB`, other bytes unchanged.
- **Both asserted**: `read=write=1` → write sequence executes and `data_rd` is unchanged.
- **Back-to-back**: write `0x1234_5678` to `0x20`, then read `0x20` in the cycle after DONE → the read returns `0x1234_5678`; stall is low only in the DONE cycles.
- **Reset mid-access**: pulse `rst` during WPULSE → `we_n=1`, `data_oe=0` at the next edge; next request starts cleanly from IDLE.

Source files
------------

// File: rtl/sram_bus_slave_pkg.sv
// Shared types and idle-level constants for the data-bus SRAM responder.
package sram_bus_slave_pkg;

    typedef logic [31:0] Word_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WSETUP,
        ST_WPULSE,
        ST_WHOLD,
        ST_DONE
    } SramState_t;

    localparam logic [3:0] SRAM_BE_IDLE = 4'b1111;
    localparam logic [3:0] SRAM_BE_FULL = 4'b0000;

endpackage

// File: rtl/sram_bus_slave_if.sv
// CPU data-bus: single-cycle request from the memory stage, stall/read-data back.
interface Bus_if;
    import sram_bus_slave_pkg::*;

    Word_t      address;
    logic       read;
    logic       write;
    Word_t      data_wr;
    logic [3:0] mask;
    Word_t      data_rd;
    logic       stall;

    modport master (
        output address, read, write, data_wr, mask,
        input  data_rd, stall
    );

    modport slave (
        input  address, read, write, data_wr, mask,
        output data_rd, stall
    );

endinterface

// File: rtl/sram_bus_slave.sv
// Turns a one-cycle bus request into a multi-cycle asynchronous SRAM access,
// stalling the master until the access completes.
module sram_bus_slave
    import sram_bus_slave_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_WIDTH  = 20
) (
    input  logic                  clk,
    input  logic                  rst,
    Bus_if.slave                  bus,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    input  Word_t                 sram_data_i,
    output Word_t                 sram_data_o,
    output logic                  sram_data_oe,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic [3:0]            sram_be_n
);

    localparam int              CNT_W    = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    SramState_t            state, state_next;
    logic [CNT_W-1:0]      cnt;
    logic [ADDR_WIDTH-1:0] addr_q;
    Word_t                 wdata_q;
    logic [3:0]            mask_q;
    Word_t                 rdata_q;
    logic                  req;
    logic                  cnt_last;
    logic                  stall;

    assign req      = bus.read | bus.write;
    assign cnt_last = (cnt == CNT_LAST);

    // Counter restarts on every state change, so it only ever counts within READ/WPULSE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            rdata_q <= '0;
        end else begin
            state <= state_next;
            if (state_next != state)
                cnt <= '0;
            else if (state == ST_READ || state == ST_WPULSE)
                cnt <= cnt + 1'b1;
            if (state == ST_READ && cnt_last)
                rdata_q <= sram_data_i;
        end
    end

    // Request registers: bus inputs are only sampled in IDLE, so in-flight writes never abort.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && req) begin
            addr_q  <= bus.address[ADDR_WIDTH+1:2];
            wdata_q <= bus.data_wr;
            mask_q  <= bus.mask;
        end
    end

    always_comb begin
        state_next   = state;
        stall        = 1'b0;
        sram_ce_n    = 1'b1;
        sram_oe_n    = 1'b1;
        sram_we_n    = 1'b1;
        sram_be_n    = SRAM_BE_IDLE;
        sram_data_oe = 1'b0;
        case (state)
            ST_IDLE: begin
                stall = req;
                if (bus.write)
                    state_next = ST_WSETUP;
                else if (bus.read)
                    state_next = ST_READ;
            end
            ST_READ: begin
                stall     = 1'b1;
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
                sram_be_n = SRAM_BE_FULL;
                if (cnt_last)
                    state_next = ST_DONE;
            end
            ST_WSETUP, ST_WPULSE, ST_WHOLD: begin
                stall        = 1'b1;
                sram_ce_n    = 1'b0;
                sram_be_n    = ~mask_q;
                sram_data_oe = 1'b1;
                if (state == ST_WSETUP) begin
                    state_next = ST_WPULSE;
                end else if (state == ST_WPULSE) begin
                    sram_we_n = 1'b0;
                    if (cnt_last)
                        state_next = ST_WHOLD;
                end else begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign sram_addr   = addr_q;
    assign sram_data_o = wdata_q;
    assign bus.data_rd = rdata_q;
    assign bus.stall   = stall;

endmodule
